// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone single-master interconnect.
// Holds the default bus geometry, the default address map (base and mask per
// slot, packed slot i at [i*AW +: AW]) and the priority one-hot helper used
// by the address decoder.
package wb_intercon_pkg;

  localparam int unsigned AwDef = 32;
  localparam int unsigned DwDef = 32;
  localparam int unsigned NsDef = 6;

  // Widest slave count the priority helper handles.
  localparam int unsigned MaxNs = 32;

  // Slot 5 down to slot 0.
  localparam logic [NsDef*AwDef-1:0] SlaveAdrDef = {
    32'h2800_0000, 32'h2300_0000, 32'h2100_0000,
    32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };

  localparam logic [NsDef*AwDef-1:0] AdrMaskDef = {NsDef{32'hFF00_0000}};

  // Keep only the lowest set bit of match.
  function automatic logic [MaxNs-1:0] onehot_first(input logic [MaxNs-1:0] match);
    logic [MaxNs-1:0] oh;
    logic             found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < MaxNs; i++) begin
      if (match[i] && !found) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/wb_intercon_decoder.sv
// Combinational address decoder for the Wishbone interconnect.
// Ports:
//   adr_i      master address
//   base_i     packed per-slot base addresses
//   mask_i     packed per-slot address masks
//   sel_o      one-hot slot select, lowest matching index wins
//   unmapped_o no slot matches the address
module wb_intercon_decoder
  import wb_intercon_pkg::*;
#(
  parameter int unsigned AW = AwDef,
  parameter int unsigned NS = NsDef
) (
  input  logic [AW-1:0]    adr_i,
  input  logic [NS*AW-1:0] base_i,
  input  logic [NS*AW-1:0] mask_i,
  output logic [NS-1:0]    sel_o,
  output logic             unmapped_o
);

  logic [NS-1:0]    match;
  logic [MaxNs-1:0] match_ext;
  logic [MaxNs-1:0] sel_ext;
  logic             unused_sel;

  always_comb begin
    match = '0;
    for (int i = 0; i < NS; i++) begin
      match[i] = ((adr_i & mask_i[i*AW +: AW]) == base_i[i*AW +: AW]);
    end
  end

  assign match_ext  = MaxNs'(match);
  assign sel_ext    = onehot_first(match_ext);
  assign sel_o      = sel_ext[NS-1:0];
  assign unmapped_o = ~|match;

  // Upper select bits are always zero; fold them away.
  assign unused_sel = ^sel_ext;

endmodule

// File: rtl/wb_interconnect.sv
// Single-master to NS-slave Wishbone address decoder and response mux.
// Slaves share the master cyc/we/sel/adr/dat lines; only stb is routed.
// Unmapped accesses are answered by an internal default responder.
// Optional watchdog enabled by defining WB_INTERCON_TIMEOUT_EN: a mapped
// slave that does not ack within TIMEOUT cycles gets answered with
// DEFAULT_DATA and its strobe is withdrawn for that cycle.
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  asynchronous active-low reset
//   wbm_adr_i  master address
//   wbm_stb_i  master strobe
//   wbm_dat_o  read data to master
//   wbm_ack_o  acknowledge to master
//   wbs_stb_o  per-slave strobe
//   wbs_dat_i  packed slave read data, slot i at [i*DW +: DW]
//   wbs_ack_i  per-slave acknowledge
module wb_interconnect
  import wb_intercon_pkg::*;
#(
  parameter int unsigned       AW           = AwDef,
  parameter int unsigned       DW           = DwDef,
  parameter int unsigned       NS           = NsDef,
  parameter logic [NS*AW-1:0]  SLAVE_ADR    = SlaveAdrDef,
  parameter logic [NS*AW-1:0]  ADR_MASK     = AdrMaskDef,
  parameter logic [DW-1:0]     DEFAULT_DATA = {DW{1'b1}},
  parameter int unsigned       TIMEOUT      = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [AW-1:0]    wbm_adr_i,
  input  logic             wbm_stb_i,
  output logic [DW-1:0]    wbm_dat_o,
  output logic             wbm_ack_o,
  output logic [NS-1:0]    wbs_stb_o,
  input  logic [NS*DW-1:0] wbs_dat_i,
  input  logic [NS-1:0]    wbs_ack_i
);

  logic [NS-1:0] sel;
  logic          unmapped;
  logic          mapped;
  logic          slv_ack;
  logic [DW-1:0] slv_dat;
  logic          dflt_ack_q, dflt_ack_d;
  logic          to_hit;
  logic          ack_int;
  logic [DW-1:0] dat_int;

  wb_intercon_decoder #(
    .AW (AW),
    .NS (NS)
  ) u_decoder (
    .adr_i      (wbm_adr_i),
    .base_i     (SLAVE_ADR),
    .mask_i     (ADR_MASK),
    .sel_o      (sel),
    .unmapped_o (unmapped)
  );

  assign mapped = ~unmapped;

  // sel is one-hot, so at most one slot drives the mux.
  always_comb begin
    slv_ack = 1'b0;
    slv_dat = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel[i]) begin
        slv_ack = wbs_ack_i[i];
        slv_dat = wbs_dat_i[i*DW +: DW];
      end
    end
  end

  // Self-clearing term makes a held strobe ack every second cycle.
  assign dflt_ack_d = wbm_stb_i & unmapped & ~dflt_ack_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      dflt_ack_q <= 1'b0;
    end else begin
      dflt_ack_q <= dflt_ack_d;
    end
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CntW-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = wbm_stb_i & mapped & ~slv_ack & (to_cnt_q == CntW'(TIMEOUT));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!wbm_stb_i || !mapped || slv_ack || to_hit) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    ack_int = 1'b0;
    dat_int = '0;
    if (to_hit) begin
      ack_int = 1'b1;
      dat_int = DEFAULT_DATA;
    end else if (mapped) begin
      ack_int = slv_ack;
      dat_int = slv_dat;
    end else if (dflt_ack_q) begin
      ack_int = 1'b1;
      dat_int = DEFAULT_DATA;
    end
  end

  // Read data stays a pure mux during reset; handshakes are held off.
  assign wbm_dat_o = dat_int;
  assign wbm_ack_o = wb_rst_ni & ack_int;
  assign wbs_stb_o = (wb_rst_ni & ~to_hit) ? ({NS{wbm_stb_i}} & sel) : '0;

endmodule

// File: tb/tb_wb_interconnect.sv
module tb_wb_interconnect;

  localparam int NS = 6;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [31:0]       adr;
  logic              stb;
  logic              we;
  logic [31:0]       wdat;
  logic [31:0]       mdat;
  logic              mack;
  logic [NS-1:0]     stb_o;
  logic [NS*DW-1:0]  sdat;
  logic [NS-1:0]     sack;

  // Behavioural RAM slaves plus per-slot overrides.
  logic [31:0]   ram [NS][16];
  logic [NS-1:0] ram_ack;
  logic [31:0]   ram_rdat [NS];
  logic [NS-1:0] mute;
  logic [NS-1:0] force_ack;
  logic [31:0]   force_dat [NS];

  // Reference model.
  logic [31:0] base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000,
                             32'h2100_0000, 32'h2300_0000, 32'h2800_0000};
  logic [31:0] mdl [NS][16];
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  int n_chk;
  int n_fail;

  wb_interconnect #(
    .TIMEOUT (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbm_adr_i (adr),
    .wbm_stb_i (stb),
    .wbm_dat_o (mdat),
    .wbm_ack_o (mack),
    .wbs_stb_o (stb_o),
    .wbs_dat_i (sdat),
    .wbs_ack_i (sack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sack = '0;
    sdat = '0;
    for (int i = 0; i < NS; i++) begin
      sack[i]           = force_ack[i] | ram_ack[i];
      sdat[i*DW +: DW]  = force_ack[i] ? force_dat[i] : ram_rdat[i];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) begin
        ram_ack[i]  <= 1'b0;
        ram_rdat[i] <= '0;
        for (int j = 0; j < 16; j++) ram[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (stb_o[i] && !ram_ack[i] && !mute[i]) begin
          ram_ack[i] <= 1'b1;
          if (we) begin
            ram[i][adr[5:2]] <= wdat;
            ram_rdat[i]      <= wdat;
          end else begin
            ram_rdat[i] <= ram[i][adr[5:2]];
          end
        end else begin
          ram_ack[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every ack seen by the master must match the next expected response.
  always @(negedge clk) begin
    if (mack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_ack: got ack with data %h expected no ack at %0t", mdat, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("ack_data", mdat, mon_exp);
      end
    end
  end

  function automatic int exp_slot(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & 32'hFF00_0000) == base[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 16; j++) mdl[i][j] = '0;
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
    int            s;
    int            n;
    logic          got;
    logic [31:0]   e;
    logic [NS-1:0] es;
    s  = exp_slot(a);
    es = '0;
    if (s < 0) begin
      e = 32'hFFFF_FFFF;
    end else begin
      es[s] = 1'b1;
      if (w) begin
        mdl[s][a[5:2]] = d;
        e = d;
      end else begin
        e = mdl[s][a[5:2]];
      end
    end
    exp_q.push_back(e);
    adr  = a;
    we   = w;
    wdat = d;
    stb  = 1'b1;
    got  = 1'b0;
    n    = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("stb_route", 32'(stb_o), 32'(es));
      if (mack) got = 1'b1;
    end
    if (got) chk("ack_latency", n, 2);
    else chk("ack_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  logic [31:0] unm [4] = '{32'h3000_0000, 32'h0100_0000, 32'hFF00_0000, 32'h2200_0000};

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          r;
    int          n;
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    adr       = 32'h3000_0000;
    stb       = 1'b0;
    we        = 1'b0;
    wdat      = '0;
    mute      = '0;
    force_ack = '0;
    for (int i = 0; i < NS; i++) force_dat[i] = '0;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(mack), 32'd0);
    chk("reset_stb", 32'(stb_o), 32'd0);
    chk("reset_dat", mdat, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Same-cycle decode and response through slot 3.
    mute[3]      = 1'b1;
    force_dat[3] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    adr          = 32'h2100_0004;
    stb          = 1'b1;
    force_ack[3] = 1'b1;
    #1;
    chk("decode_stb", 32'(stb_o), 32'b001000);
    chk("decode_ack", 32'(mack), 32'd1);
    chk("decode_dat", mdat, 32'h1234_5678);
    @(posedge clk);
    #1;
    stb          = 1'b0;
    force_ack[3] = 1'b0;
    mute[3]      = 1'b0;
    @(posedge clk);
    #1;

    // Write then read every slot.
    for (int s = 0; s < NS; s++) begin
      a = base[s] | 32'($urandom_range(0, 15) << 2);
      d = $urandom;
      access(a, 1'b1, d);
      access(a, 1'b0, 32'd0);
    end

    // Isolation: slot 5 acks constantly while slot 0 is accessed.
    force_dat[5] = 32'hDEAD_BEEF;
    force_ack[5] = 1'b1;
    access(32'h0000_0008, 1'b0, 32'd0);
    force_ack[5] = 1'b0;

    // Unmapped access.
    access(32'h3000_0000, 1'b0, 32'd0);

    // Held strobe on an unmapped address acks every second cycle.
    repeat (3) exp_q.push_back(32'hFFFF_FFFF);
    adr = 32'h3000_0000;
    stb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("dflt_repeat", 32'(mack), 32'(k % 2));
    end
    @(posedge clk);
    #1;
    stb = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-access while the default ack is up.
    exp_q.push_back(32'hFFFF_FFFF);
    adr = 32'h3000_0000;
    stb = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("rst_mid_ack", 32'(mack), 32'd0);
    adr = 32'h1000_0000;
    #1;
    chk("rst_mid_stb", 32'(stb_o), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    stb   = 1'b0;
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    access(32'h1000_0010, 1'b1, 32'hA5A5_0001);
    access(32'h1000_0010, 1'b0, 32'd0);

`ifdef WB_INTERCON_TIMEOUT_EN
    // Silent slot-2 slave gets answered by the watchdog.
    mute[2] = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    adr = 32'h2000_0000;
    stb = 1'b1;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mack && n < 20);
    chk("timeout_latency", n, 5);
    chk("timeout_stb", 32'(stb_o), 32'd0);
    @(posedge clk);
    #1;
    stb     = 1'b0;
    mute[2] = 1'b0;
    @(posedge clk);
    #1;
`endif

    // Randomized traffic against the reference model.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 6);
      if (r == 6) a = unm[$urandom_range(0, 3)];
      else a = base[r];
      a = a | 32'($urandom_range(0, 15) << 2);
      access(a, 1'($urandom_range(0, 1)), $urandom);
    end

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    n = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
